// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer and the iterator blocks it drives:
// state encoding, counter widths and a small state-class helper.
package layer_sequencer_pkg;

    localparam int STATE_W = 4;
    localparam int WDOG_W  = 16;
    localparam int DRAIN_W = 4;
    localparam int LAYER_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 4'd0,
        CONV_GO    = 4'd1,
        CONV_RUN   = 4'd2,
        CONV_DRAIN = 4'd3,
        POOL_GO    = 4'd4,
        POOL_RUN   = 4'd5,
        POOL_DRAIN = 4'd6,
        NEXT       = 4'd7,
        DONE       = 4'd8
    } seq_state_t;

    // True while an iterator is working and the watchdog must be running.
    function automatic logic is_run_state(input seq_state_t s);
        return (s == CONV_RUN) || (s == POOL_RUN);
    endfunction

    // True while waiting out the settle time after an iterator finished.
    function automatic logic is_drain_state(input seq_state_t s);
        return (s == CONV_DRAIN) || (s == POOL_DRAIN);
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and its iterators / host.
// The master side is the sequencer itself; the slave side is whatever drives
// start and the iterator ready pulses.
interface layer_sequencer_if;
    import layer_sequencer_pkg::*;

    logic               start;
    logic               conv_go;
    logic               conv_ready;
    logic               pool_go;
    logic               pool_ready;
    logic               buf_sel;
    logic [LAYER_W-1:0] layer_idx;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start,
        input  conv_ready,
        input  pool_ready,
        output conv_go,
        output pool_go,
        output buf_sel,
        output layer_idx,
        output busy,
        output done,
        output err
    );

    modport slave (
        output start,
        output conv_ready,
        output pool_ready,
        input  conv_go,
        input  pool_go,
        input  buf_sel,
        input  layer_idx,
        input  busy,
        input  done,
        input  err
    );

endinterface

// File: rtl/layer_sequencer_wait_cnt.sv
// Reusable wait counter: cleared by load, counts up while enabled and
// saturates at all-ones so it can never wrap, and flags when the count
// equals the supplied limit.
module seq_wait_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;

    // Count register: load restarts from zero, enable advances until saturated.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign tc = (cnt_q == limit);

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks NUM_LAYERS conv+pool layer pairs, firing one-cycle
// go pulses to the iterators, waiting for their ready pulses, inserting a
// settle gap after each ready and flipping the ping-pong buffer per layer.
// A watchdog aborts a run whose iterator never answers.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS   = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int TIMEOUT      = 4096
) (
    input logic               clk,
    input logic               rstn,
    layer_sequencer_if.master seq
);

    // Watchdog fires in the TIMEOUT-th run cycle; drain ends in its last cycle.
    localparam logic [WDOG_W-1:0]  WDOG_LIMIT  = WDOG_W'(TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LIMIT =
        (DRAIN_CYCLES == 0) ? DRAIN_W'(0) : DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER  = LAYER_W'(NUM_LAYERS - 1);
    localparam bit                 HAS_DRAIN   = (DRAIN_CYCLES != 0);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic               timeout_hit;

    logic               wdog_load;
    logic               wdog_en;
    logic               wdog_tc;
    logic               drain_load;
    logic               drain_en;
    logic               drain_tc;

    logic               conv_go;
    logic               pool_go;
    logic               busy;
    logic               done;

    logic               buf_sel_q;
    logic [LAYER_W-1:0] layer_idx_q;
    logic               err_q;

    seq_wait_cnt #(.WIDTH(WDOG_W)) u_wdog (
        .clk   (clk),
        .rstn  (rstn),
        .load  (wdog_load),
        .en    (wdog_en),
        .limit (WDOG_LIMIT),
        .tc    (wdog_tc)
    );

    seq_wait_cnt #(.WIDTH(DRAIN_W)) u_drain (
        .clk   (clk),
        .rstn  (rstn),
        .load  (drain_load),
        .en    (drain_en),
        .limit (DRAIN_LIMIT),
        .tc    (drain_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a ready in the same cycle as the watchdog limit wins.
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (seq.start) begin
                    state_d = CONV_GO;
                end
            end
            CONV_GO: begin
                state_d = CONV_RUN;
            end
            CONV_RUN: begin
                if (seq.conv_ready) begin
                    state_d = HAS_DRAIN ? CONV_DRAIN : POOL_GO;
                end else if (wdog_tc) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            CONV_DRAIN: begin
                if (drain_tc) begin
                    state_d = POOL_GO;
                end
            end
            POOL_GO: begin
                state_d = POOL_RUN;
            end
            POOL_RUN: begin
                if (seq.pool_ready) begin
                    state_d = HAS_DRAIN ? POOL_DRAIN : NEXT;
                end else if (wdog_tc) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            POOL_DRAIN: begin
                if (drain_tc) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                state_d = (layer_idx_q == LAST_LAYER) ? DONE : CONV_GO;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs and counter controls decoded purely from the current state.
    always_comb begin
        conv_go    = (state_q == CONV_GO);
        pool_go    = (state_q == POOL_GO);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        wdog_load  = (state_q == CONV_GO) || (state_q == POOL_GO);
        wdog_en    = is_run_state(state_q);
        drain_load = is_run_state(state_q);
        drain_en   = is_drain_state(state_q);
    end

    // Layer index: advance between layers, return to zero when a run ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            layer_idx_q <= '0;
        end else if ((state_q == NEXT) && (layer_idx_q != LAST_LAYER)) begin
            layer_idx_q <= layer_idx_q + LAYER_W'(1);
        end else if ((state_q == DONE) || timeout_hit) begin
            layer_idx_q <= '0;
        end
    end

    // Ping-pong bank flips once per finished layer and survives between runs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_sel_q <= 1'b0;
        end else if (state_q == NEXT) begin
            buf_sel_q <= ~buf_sel_q;
        end
    end

    // Sticky error: set by the watchdog, cleared only by an accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && seq.start) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign seq.conv_go   = conv_go;
    assign seq.pool_go   = pool_go;
    assign seq.busy      = busy;
    assign seq.done      = done;
    assign seq.buf_sel   = buf_sel_q;
    assign seq.layer_idx = layer_idx_q;
    assign seq.err       = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer. The stimulus side plans each run
// as a timeline (start, ready pulses) and predicts every go/done event with
// its cycle, layer and bank; a monitor pops and compares as events appear.
module tb_layer_sequencer;

    localparam int NUM_LAYERS   = 2;
    localparam int DRAIN_CYCLES = 3;
    localparam int TIMEOUT      = 64;

    typedef struct {
        int cyc;
        int kind;   // 0 conv_go, 1 pool_go, 2 done
        int layer;
        int bsel;
    } ev_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    layer_sequencer_if seq_if ();

    layer_sequencer #(
        .NUM_LAYERS   (NUM_LAYERS),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .seq  (seq_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_checks = 0;
    int  n_pass   = 0;
    ev_t exp_q[$];
    int  c_lo[$], c_hi[$], p_lo[$], p_hi[$], c_rdy[$], p_rdy[$];
    int  c_lat[NUM_LAYERS];
    int  p_lat[NUM_LAYERS];
    bit  model_buf = 1'b0;
    bit  model_err = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) tick();
    endtask

    function automatic bit in_window(input int c, input bit pool);
        if (pool) begin
            foreach (p_lo[i]) if (c >= p_lo[i] && c <= p_hi[i]) return 1'b1;
        end else begin
            foreach (c_lo[i]) if (c >= c_lo[i] && c <= c_hi[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit is_ready_cycle(input int c, input bit pool);
        if (pool) begin
            foreach (p_rdy[i]) if (p_rdy[i] == c) return 1'b1;
        end else begin
            foreach (c_rdy[i]) if (c_rdy[i] == c) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Plan one run from c_lat/p_lat (latency in run cycles, 0 = never ready),
    // predict its events, then drive it, optionally with ignored noise pulses.
    task automatic applyStimulus(input int t_start, input bit noise);
        int g, r, p, r2, n, end_busy;
        bit b, timed_out;
        c_lo.delete(); c_hi.delete(); p_lo.delete(); p_hi.delete();
        c_rdy.delete(); p_rdy.delete();
        timed_out = 1'b0;
        b         = model_buf;
        g         = t_start + 1;
        end_busy  = g;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            exp_q.push_back('{g, 0, l, int'(b)});
            if (c_lat[l] == 0) begin
                c_lo.push_back(g + 1); c_hi.push_back(g + TIMEOUT);
                end_busy = g + TIMEOUT; timed_out = 1'b1;
                break;
            end
            r = g + c_lat[l];
            c_lo.push_back(g + 1); c_hi.push_back(r); c_rdy.push_back(r);
            p = r + DRAIN_CYCLES + 1;
            exp_q.push_back('{p, 1, l, int'(b)});
            if (p_lat[l] == 0) begin
                p_lo.push_back(p + 1); p_hi.push_back(p + TIMEOUT);
                end_busy = p + TIMEOUT; timed_out = 1'b1;
                break;
            end
            r2 = p + p_lat[l];
            p_lo.push_back(p + 1); p_hi.push_back(r2); p_rdy.push_back(r2);
            n = r2 + DRAIN_CYCLES + 1;
            b = ~b;
            if (l == NUM_LAYERS - 1) begin
                exp_q.push_back('{n + 1, 2, l, int'(b)});
                end_busy = n + 1;
            end else begin
                g = n + 1;
            end
        end

        for (int c = cyc; c <= end_busy; c++) begin
            waitUntil(c);
            if (c == t_start) checkOutput("err_before_start", int'(seq_if.err), int'(model_err));
            if (c == t_start + 1) begin
                checkOutput("busy_after_start", int'(seq_if.busy), 1);
                checkOutput("err_cleared_by_start", int'(seq_if.err), 0);
            end
            seq_if.start      = (c == t_start) ||
                                (noise && c > t_start && $urandom_range(0, 7) == 0);
            seq_if.conv_ready = is_ready_cycle(c, 1'b0) ||
                                (noise && !in_window(c, 1'b0) && $urandom_range(0, 5) == 0);
            seq_if.pool_ready = is_ready_cycle(c, 1'b1) ||
                                (noise && !in_window(c, 1'b1) && $urandom_range(0, 5) == 0);
        end
        waitUntil(end_busy + 1);
        seq_if.start      = 1'b0;
        seq_if.conv_ready = 1'b0;
        seq_if.pool_ready = 1'b0;
        checkOutput("busy_after_run", int'(seq_if.busy), 0);
        checkOutput("done_after_run", int'(seq_if.done), 0);
        checkOutput("err_after_run", int'(seq_if.err), int'(timed_out));
        checkOutput("buf_sel_after_run", int'(seq_if.buf_sel), int'(b));
        if (!timed_out) checkOutput("layer_idx_after_run", int'(seq_if.layer_idx), 0);
        model_buf = b;
        model_err = timed_out;
    endtask

    // Abort a run with reset in the middle of the first pool drain.
    task automatic resetDuringPoolDrain();
        int t_start, g, r, p, r2, rst_cyc;
        t_start = cyc + 2;
        g  = t_start + 1;
        r  = g + 5;
        p  = r + DRAIN_CYCLES + 1;
        r2 = p + 4;
        rst_cyc = r2 + 2;
        exp_q.push_back('{g, 0, 0, int'(model_buf)});
        exp_q.push_back('{p, 1, 0, int'(model_buf)});
        for (int c = cyc; c < rst_cyc; c++) begin
            waitUntil(c);
            seq_if.start      = (c == t_start);
            seq_if.conv_ready = (c == r);
            seq_if.pool_ready = (c == r2);
        end
        waitUntil(rst_cyc);
        seq_if.start      = 1'b0;
        seq_if.conv_ready = 1'b0;
        seq_if.pool_ready = 1'b0;
        checkOutput("busy_in_pool_drain", int'(seq_if.busy), 1);
        rstn = 1'b0;
        #1;
        checkOutput("rst_mid_conv_go", int'(seq_if.conv_go), 0);
        checkOutput("rst_mid_pool_go", int'(seq_if.pool_go), 0);
        checkOutput("rst_mid_busy", int'(seq_if.busy), 0);
        checkOutput("rst_mid_done", int'(seq_if.done), 0);
        checkOutput("rst_mid_err", int'(seq_if.err), 0);
        checkOutput("rst_mid_buf_sel", int'(seq_if.buf_sel), 0);
        checkOutput("rst_mid_layer_idx", int'(seq_if.layer_idx), 0);
        repeat (3) tick();
        rstn      = 1'b1;
        model_buf = 1'b0;
        model_err = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            seq_if.conv_ready = ($urandom_range(0, 3) == 0);
            seq_if.pool_ready = ($urandom_range(0, 3) == 0);
        end
        seq_if.conv_ready = 1'b0;
        seq_if.pool_ready = 1'b0;
        checkOutput("busy_after_reset_release", int'(seq_if.busy), 0);
    endtask

    // Monitor: every go/done pulse must match the oldest predicted event.
    always @(negedge clk) begin
        ev_t front;
        int  kind;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checkOutput("missed_event_cycle", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (seq_if.conv_go || seq_if.pool_go || seq_if.done) begin
            kind = seq_if.conv_go ? 0 : (seq_if.pool_go ? 1 : 2);
            checkOutput("event_onehot",
                        int'(seq_if.conv_go) + int'(seq_if.pool_go) + int'(seq_if.done), 1);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_event_kind", kind, -1);
            end else begin
                front = exp_q.pop_front();
                checkOutput("event_cycle", cyc, front.cyc);
                checkOutput("event_kind", kind, front.kind);
                checkOutput("event_layer_idx", int'(seq_if.layer_idx), front.layer);
                checkOutput("event_buf_sel", int'(seq_if.buf_sel), front.bsel);
            end
        end
    end

    // Hard stop in case something never settles.
    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Main sequence: reset, directed runs, watchdog cases, reset abort, random runs.
    initial begin
        seq_if.start      = 1'b0;
        seq_if.conv_ready = 1'b0;
        seq_if.pool_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset_conv_go", int'(seq_if.conv_go), 0);
        checkOutput("reset_pool_go", int'(seq_if.pool_go), 0);
        checkOutput("reset_busy", int'(seq_if.busy), 0);
        checkOutput("reset_done", int'(seq_if.done), 0);
        checkOutput("reset_err", int'(seq_if.err), 0);
        checkOutput("reset_buf_sel", int'(seq_if.buf_sel), 0);
        checkOutput("reset_layer_idx", int'(seq_if.layer_idx), 0);
        waitUntil(3);
        rstn = 1'b1;

        $display("[TB] directed: start at 10, conv_ready at 20, full two-layer run");
        c_lat[0] = 9;  p_lat[0] = 5;
        c_lat[1] = 7;  p_lat[1] = 5;
        applyStimulus(10, 1'b0);

        $display("[TB] watchdog timeout in conv run");
        c_lat[0] = 0;  p_lat[0] = 3;
        c_lat[1] = 3;  p_lat[1] = 3;
        applyStimulus(cyc + 3, 1'b0);
        repeat (4) tick();
        checkOutput("err_sticky_idle", int'(seq_if.err), 1);

        $display("[TB] ready coinciding with watchdog limit, with noise");
        c_lat[0] = TIMEOUT; p_lat[0] = 10;
        c_lat[1] = 3;       p_lat[1] = TIMEOUT;
        applyStimulus(cyc + 2, 1'b1);

        $display("[TB] watchdog timeout in pool run");
        c_lat[0] = 4;  p_lat[0] = 0;
        c_lat[1] = 4;  p_lat[1] = 4;
        applyStimulus(cyc + 2, 1'b1);

        $display("[TB] reset during pool drain");
        resetDuringPoolDrain();

        $display("[TB] randomized runs with noise");
        for (int k = 0; k < 8; k++) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
                c_lat[l] = int'($urandom_range(1, 24));
                p_lat[l] = int'($urandom_range(1, 24));
            end
            applyStimulus(cyc + 1 + int'($urandom_range(0, 4)), 1'b1);
        end

        waitUntil(cyc + 20);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
